// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target shifter: default widths, mode constants
// and the frame state encoding.
package spi_pkg;

    localparam int DATA_W_DEFAULT      = 8;
    localparam int SYNC_STAGES_DEFAULT = 2;

    // Only SPI mode 0 is supported: sck idles low, data sampled on the rising edge.
    localparam bit SPI_CPOL = 1'b0;
    localparam bit SPI_CPHA = 1'b0;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_tgt_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with single-cycle rise and
// fall pulses derived from one extra flop behind the synchronised level.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int   STAGES    = SYNC_STAGES_DEFAULT,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            last_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            last_q <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~last_q;
    assign fall = ~sync_q[STAGES-1] & last_q;

endmodule

// File: rtl/spi_target_shifter.sv
// SPI mode-0 target front end: oversamples sck/csn/mosi in the clk domain,
// deserialises MOSI into words and serialises a one-entry holding register onto MISO.
module spi_target_shifter
    import spi_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sck,
    input  logic              csn,
    input  logic              mosi,
    output logic              miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_underrun,
    output logic              busy
);

    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    spi_tgt_state_e    state_q, state_d;
    logic              sck_rise, sck_fall, csn_rise, csn_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic              mosi_s;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic              word_done_q;
    logic [DATA_W-2:0] rx_shift_q;
    logic [DATA_W-1:0] rx_next;
    logic [DATA_W-1:0] tx_shift_q;
    logic [DATA_W-1:0] hold_q;
    logic              hold_full_q;
    logic [DATA_W-1:0] load_word;
    logic              tx_write;
    logic              frame_start, frame_abort, bit_rise, bit_fall, word_load;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (sck),
        .rise     (sck_rise),
        .fall     (sck_fall)
    );

    // csn resets to 0 so that a pin already low out of reset produces no fall:
    // a frame only starts after csn has been seen high and then low again.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_csn_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (csn),
        .rise     (csn_rise),
        .fall     (csn_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mosi_sync_q <= '0;
        else        mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    end

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // A csn rise wins over any sck edge detected in the same cycle.
    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        frame_abort = 1'b0;
        bit_rise    = 1'b0;
        bit_fall    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (csn_fall) begin
                    state_d     = ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ACTIVE: begin
                if (csn_rise) begin
                    state_d     = IDLE;
                    frame_abort = 1'b1;
                end else begin
                    bit_rise = sck_rise;
                    bit_fall = sck_fall;
                end
            end
            default: state_d = IDLE;
        endcase
        word_load = frame_start || (bit_fall && (bit_cnt_q == '0) && word_done_q);
    end

    assign load_word = hold_full_q ? hold_q : '0;
    assign tx_write  = tx_valid && !hold_full_q;
    assign rx_next   = {rx_shift_q, mosi_s};

    // miso is the MSB of the shift-out flop, so it is registered and reads 0 when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q   <= '0;
            word_done_q <= 1'b0;
            rx_shift_q  <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;

            if (tx_write) begin
                hold_q      <= tx_data;
                hold_full_q <= 1'b1;
            end else if (word_load && hold_full_q) begin
                hold_full_q <= 1'b0;
            end

            if (frame_start) begin
                bit_cnt_q   <= '0;
                word_done_q <= 1'b0;
                rx_shift_q  <= '0;
            end

            if (frame_abort) begin
                tx_shift_q <= '0;
            end else if (word_load) begin
                tx_shift_q  <= load_word;
                tx_underrun <= !hold_full_q;
            end else if (bit_fall) begin
                tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
            end

            if (bit_rise) begin
                rx_shift_q <= rx_next[DATA_W-2:0];
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_q   <= '0;
                    word_done_q <= 1'b1;
                    rx_data     <= rx_next;
                    rx_valid    <= 1'b1;
                end else begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                end
            end
        end
    end

    assign miso     = tx_shift_q[DATA_W-1];
    assign tx_ready = !hold_full_q;
    assign busy     = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_target_shifter.sv
// Scenario bench for spi_target_shifter: drives SPI frames as an initiator and
// checks received words through a scoreboard queue.
module tb_spi_target_shifter;

    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;
    localparam int HALF        = SYNC_STAGES + 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              sck;
    logic              csn;
    logic              mosi;
    logic              miso;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_underrun;
    logic              busy;

    int checks       = 0;
    int failures     = 0;
    int rx_cnt       = 0;
    int underrun_cnt = 0;
    logic [DATA_W-1:0] rx_q[$];
    logic [DATA_W-1:0] exp_word;

    spi_target_shifter #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sck         (sck),
        .csn         (csn),
        .mosi        (mosi),
        .miso        (miso),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_underrun (tx_underrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Scoreboard side: every rx_valid pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (tx_underrun) underrun_cnt++;
        if (rx_valid) begin
            rx_cnt++;
            checks++;
            if (rx_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL rx_unexpected: rx_valid with rx_data=%h, expected no word", rx_data);
            end else begin
                exp_word = rx_q.pop_front();
                if (rx_data !== exp_word) begin
                    failures++;
                    $display("[TB] FAIL rx_data: got %h, expected %h", rx_data, exp_word);
                end
            end
        end
    end

    task automatic tx_write(input logic [DATA_W-1:0] d);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic spi_bits(input logic [DATA_W-1:0] mo, input int nbits, output logic [DATA_W-1:0] mi);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[DATA_W-1-i];
            repeat (HALF) @(negedge clk);
            mi[DATA_W-1-i] = miso;
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic frame_end();
        repeat (HALF) @(negedge clk);
        csn = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic test_reset();
        checks++; if (miso !== 1'b0) begin failures++; $display("[TB] FAIL reset_miso: got %b, expected 0", miso); end
        checks++; if (rx_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_rx_data: got %h, expected 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rx_valid: got %b, expected 0", rx_valid); end
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_tx_ready: got %b, expected 1", tx_ready); end
        checks++; if (tx_underrun !== 1'b0) begin failures++; $display("[TB] FAIL reset_tx_underrun: got %b, expected 0", tx_underrun); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    endtask

    task automatic test_single_word();
        logic [DATA_W-1:0] mi;
        int base_u;
        base_u = underrun_cnt;
        tx_write(8'hA5);
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("[TB] FAIL single_tx_ready_full: got %b, expected 0", tx_ready); end
        rx_q.push_back(8'h3C);
        csn = 1'b0;
        spi_bits(8'h3C, 8, mi);
        checks++; if (mi !== 8'hA5) begin failures++; $display("[TB] FAIL single_miso: got %h, expected a5", mi); end
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL single_busy: got %b, expected 1", busy); end
        frame_end();
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("[TB] FAIL single_tx_ready_empty: got %b, expected 1", tx_ready); end
        checks++; if (miso !== 1'b0) begin failures++; $display("[TB] FAIL single_miso_idle: got %b, expected 0", miso); end
        checks++; if (underrun_cnt - base_u !== 1) begin failures++; $display("[TB] FAIL single_underruns: got %0d, expected 1", underrun_cnt - base_u); end
        checks++; if (rx_q.size() !== 0) begin failures++; $display("[TB] FAIL single_rx_missing: got %0d pending, expected 0", rx_q.size()); end
    endtask

    task automatic test_two_words();
        logic [DATA_W-1:0] mi;
        int base_u;
        base_u = underrun_cnt;
        tx_write(8'hA5);
        rx_q.push_back(8'h12);
        rx_q.push_back(8'hFE);
        csn = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("[TB] FAIL two_tx_ready_after_load: got %b, expected 1", tx_ready); end
        tx_write(8'h81);
        spi_bits(8'h12, 8, mi);
        checks++; if (mi !== 8'hA5) begin failures++; $display("[TB] FAIL two_miso_word0: got %h, expected a5", mi); end
        spi_bits(8'hFE, 8, mi);
        checks++; if (mi !== 8'h81) begin failures++; $display("[TB] FAIL two_miso_word1: got %h, expected 81", mi); end
        frame_end();
        checks++; if (underrun_cnt - base_u !== 1) begin failures++; $display("[TB] FAIL two_underruns: got %0d, expected 1", underrun_cnt - base_u); end
        checks++; if (rx_q.size() !== 0) begin failures++; $display("[TB] FAIL two_rx_missing: got %0d pending, expected 0", rx_q.size()); end
    endtask

    task automatic test_underrun();
        logic [DATA_W-1:0] mi;
        int base_u;
        base_u = underrun_cnt;
        rx_q.push_back(8'h5A);
        csn = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (underrun_cnt - base_u !== 1) begin failures++; $display("[TB] FAIL underrun_at_start: got %0d, expected 1", underrun_cnt - base_u); end
        spi_bits(8'h5A, 8, mi);
        checks++; if (mi !== 8'h00) begin failures++; $display("[TB] FAIL underrun_miso: got %h, expected 00", mi); end
        frame_end();
        checks++; if (underrun_cnt - base_u !== 2) begin failures++; $display("[TB] FAIL underrun_total: got %0d, expected 2", underrun_cnt - base_u); end
        checks++; if (rx_q.size() !== 0) begin failures++; $display("[TB] FAIL underrun_rx_missing: got %0d pending, expected 0", rx_q.size()); end
    endtask

    task automatic test_abort();
        logic [DATA_W-1:0] mi;
        int base_u, base_rx;
        base_u  = underrun_cnt;
        base_rx = rx_cnt;
        tx_write(8'hC3);
        csn = 1'b0;
        spi_bits(8'h77, 5, mi);
        checks++; if (mi !== 8'hC0) begin failures++; $display("[TB] FAIL abort_partial_miso: got %h, expected c0", mi); end
        frame_end();
        checks++; if (miso !== 1'b0) begin failures++; $display("[TB] FAIL abort_miso: got %b, expected 0", miso); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy: got %b, expected 0", busy); end
        checks++; if (rx_cnt - base_rx !== 0) begin failures++; $display("[TB] FAIL abort_rx_count: got %0d, expected 0", rx_cnt - base_rx); end
        checks++; if (underrun_cnt - base_u !== 0) begin failures++; $display("[TB] FAIL abort_underruns: got %0d, expected 0", underrun_cnt - base_u); end
        tx_write(8'h69);
        rx_q.push_back(8'h96);
        csn = 1'b0;
        spi_bits(8'h96, 8, mi);
        checks++; if (mi !== 8'h69) begin failures++; $display("[TB] FAIL abort_next_miso: got %h, expected 69", mi); end
        frame_end();
        checks++; if (rx_q.size() !== 0) begin failures++; $display("[TB] FAIL abort_rx_missing: got %0d pending, expected 0", rx_q.size()); end
    endtask

    task automatic test_tx_not_ready();
        logic [DATA_W-1:0] mi;
        tx_write(8'hA5);
        tx_write(8'hFF);
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("[TB] FAIL notready_tx_ready: got %b, expected 0", tx_ready); end
        rx_q.push_back(8'h00);
        csn = 1'b0;
        spi_bits(8'h00, 8, mi);
        checks++; if (mi !== 8'hA5) begin failures++; $display("[TB] FAIL notready_miso: got %h, expected a5", mi); end
        frame_end();
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("[TB] FAIL notready_tx_ready_end: got %b, expected 1", tx_ready); end
        checks++; if (rx_q.size() !== 0) begin failures++; $display("[TB] FAIL notready_rx_missing: got %0d pending, expected 0", rx_q.size()); end
    endtask

    task automatic test_reset_mid_frame();
        logic [DATA_W-1:0] mi;
        int base_u, base_rx;
        tx_write(8'hA5);
        csn = 1'b0;
        spi_bits(8'hF0, 3, mi);
        rst_n = 1'b0;
        #1;
        checks++; if (miso !== 1'b0) begin failures++; $display("[TB] FAIL midrst_miso: got %b, expected 0", miso); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy: got %b, expected 0", busy); end
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("[TB] FAIL midrst_tx_ready: got %b, expected 1", tx_ready); end
        checks++; if (rx_data !== 8'h00) begin failures++; $display("[TB] FAIL midrst_rx_data: got %h, expected 00", rx_data); end
        @(negedge clk);
        rst_n   = 1'b1;
        base_u  = underrun_cnt;
        base_rx = rx_cnt;
        spi_bits(8'hFF, 8, mi);
        checks++; if (mi !== 8'h00) begin failures++; $display("[TB] FAIL midrst_ignored_miso: got %h, expected 00", mi); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_ignored_busy: got %b, expected 0", busy); end
        frame_end();
        checks++; if (rx_cnt - base_rx !== 0) begin failures++; $display("[TB] FAIL midrst_rx_count: got %0d, expected 0", rx_cnt - base_rx); end
        checks++; if (underrun_cnt - base_u !== 0) begin failures++; $display("[TB] FAIL midrst_underruns: got %0d, expected 0", underrun_cnt - base_u); end
        tx_write(8'h5B);
        rx_q.push_back(8'hC7);
        csn = 1'b0;
        spi_bits(8'hC7, 8, mi);
        checks++; if (mi !== 8'h5B) begin failures++; $display("[TB] FAIL midrst_next_miso: got %h, expected 5b", mi); end
        frame_end();
        checks++; if (rx_q.size() !== 0) begin failures++; $display("[TB] FAIL midrst_rx_missing: got %0d pending, expected 0", rx_q.size()); end
    endtask

    initial begin
        rst_n    = 1'b0;
        sck      = 1'b0;
        csn      = 1'b1;
        mosi     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        test_reset();
        test_single_word();
        test_two_words();
        test_underrun();
        test_abort();
        test_tx_not_ready();
        test_reset_mid_frame();
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_target_shifter.md
# spi_target_shifter

Clocked SPI target (slave) front end that sits directly downstream of the SPI initiator BFM on the `sck`/`csn`/`mosi`/`miso` wires. It oversamples the SPI pins in the system `clk` domain, deserialises MOSI into parallel words for the target's register logic, and serialises a one-entry transmit holding register onto MISO. SPI mode 0 only (CPOL=0, CPHA=0), MSB first, `csn` active-low.

## Interface
- `DATA_W`, 8: word width in bits, ≥ 2.
- `SYNC_STAGES`, 2: synchroniser flops on `sck`, `csn`, `mosi`, ≥ 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sck`  in  1  SPI clock from initiator, asynchronous to `clk`.
- `csn`  in  1  chip select, active-low, asynchronous.
- `mosi`  in  1  serial data from initiator.
- `miso`  out  1  serial data to initiator, registered.
- `rx_data`  out  DATA_W  last complete received word.
- `rx_valid`  out  1  one-cycle pulse; `rx_data` valid that cycle.
- `tx_data`  in  DATA_W  next word to transmit.
- `tx_valid`  in  1  `tx_data` offered.
- `tx_ready`  out  1  holding register empty; write accepted when `tx_valid && tx_ready`.
- `tx_underrun`  out  1  one-cycle pulse: word boundary reached with holding register empty.
- `busy`  out  1  frame in progress (synchronised `csn` low).

## Operation
- Synchronise `sck`, `csn`, `mosi` through `SYNC_STAGES` flops; a further flop on `sck`/`csn` gives edge detect. All decisions use synchronised values only.
- States: IDLE (csn high), ACTIVE. IDLE→ACTIVE on csn falling edge; ACTIVE→IDLE on csn rising edge.
- Frame start (csn fall): bit counter ← 0; shift-out ← holding register (marks it empty) or all-zero with `tx_underrun` pulse if empty; `miso` ← MSB of loaded word.
- `sck` rising edge in ACTIVE: shift synchronised `mosi` into rx shift register LSB; counter +1. On the `DATA_W`-th rise: `rx_data` ← completed word, `rx_valid` pulse, counter wraps to 0.
- `sck` falling edge in ACTIVE: if counter = 0 and at least one word completed in this frame, load next word from holding register (or zero + `tx_underrun`) and drive its MSB; otherwise shift out next bit.
- `csn` rise mid-word: partial rx bits discarded, no `rx_valid`; partly sent tx word lost; holding register untouched; `miso` ← 0.
- `miso` = 0 whenever IDLE. No tristate.
- `sck` edges while IDLE ignored.
- Holding register: written on `tx_valid && tx_ready`; `tx_ready` is registered state (empty flag). Load and write in same cycle: load sees empty (underrun, zero sent), write fills holding register.
- Reset: `miso`=0, `rx_data`=0, `rx_valid`=0, `tx_ready`=1, `tx_underrun`=0, `busy`=0, state IDLE, counters/shift registers 0. Reset mid-frame aborts the frame; out of reset with `csn` low, no frame starts until csn goes high then low.

## Timing
- Detection latency: edge acted on in the cycle `SYNC_STAGES`+1 clk edges after the first synchroniser flop captures it.
- `rx_valid` asserted the cycle after the `DATA_W`-th rise is detected; `rx_data` held until next completed word.
- `miso` updates the cycle after a fall (or csn fall) is detected.
- Requirement on initiator: `sck` high and low phases each ≥ `SYNC_STAGES`+2 `clk` periods; `csn` fall to first `sck` rise ≥ `SYNC_STAGES`+3 periods; last `sck` fall to `csn` rise ≥ `SYNC_STAGES`+2 periods.

## Structure
- Package `spi_pkg`: `DATA_W` default, state enum `spi_tgt_state_e` {IDLE, ACTIVE}, mode constant (CPOL/CPHA = 0).
- Sub-module `spi_sync_edge`: N-stage synchroniser plus rise/fall pulse outputs; instanced for `sck` and `csn` (`mosi` uses sync only).

## Test plan
- Write 0xA5, frame of 8 `sck` with mosi 0x3C → `miso` bits 1,0,1,0,0,1,0,1; one `rx_valid` with `rx_data`=0x3C; `tx_ready` back to 1.
- Two-word frame, holding refilled with 0x81 after first load, mosi 0x12,0xFE → miso 0xA5 then 0x81; two `rx_valid` pulses 0x12, 0xFE.
- Frame with holding empty → `tx_underrun` pulse at csn fall, miso all zero, rx still received.
- csn raised after 5 bits → no `rx_valid`, `miso`=0, next full frame receives correct word.
- `rst_n` low for 1 cycle mid-word → all outputs at reset values immediately; frame ignored until csn cycles.
- `tx_valid` when `tx_ready`=0 → not accepted, holding value unchanged (checks 0xA5 sent, not new data).
